// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO unit: operation codes, state encodings
// and the default watchdog limit.
package hilo_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/hilo_watchdog.sv
// Cycle counter bounding how long the HI/LO unit waits on the multiplier;
// terminal flags the last permitted wait cycle.
module hilo_watchdog
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: sequences the shift-add multiplier and services MTHI/MTLO/MFHI/MFLO.
// Optional macro HILO_BYPASS_EN forwards the finishing product to rd_data and drops busy in WRITE.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_finished,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] rd_data
);

  logic [1:0] state;
  logic       wd_terminal;
  logic       wd_enable;

  assign wd_enable = (state == ST_WAIT) && !mult_finished;

  hilo_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_START),
    .enable  (wd_enable),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      hi_out <= '0;
      lo_out <= '0;
      mult_a <= '0;
      mult_b <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MULT: begin
                mult_a <= rs_data;
                mult_b <= rt_data;
                state  <= ST_START;
              end
              OP_MTHI: hi_out <= rs_data;
              OP_MTLO: lo_out <= rs_data;
              default: ;
            endcase
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          // The finished flag wins over the watchdog on the last permitted cycle.
          if (mult_finished) begin
            hi_out <= mult_hi;
            lo_out <= mult_lo;
            state  <= ST_WRITE;
          end else if (wd_terminal) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mult_start = (state == ST_START);
  assign done       = (state == ST_WRITE);

`ifdef HILO_BYPASS_EN
  assign busy = (state != ST_IDLE) && (state != ST_WRITE);
`else
  assign busy = (state != ST_IDLE);
`endif

  always_comb begin
    rd_data = '0;
    if (op_valid) begin
      case (op_code)
        OP_MFHI: rd_data = hi_out;
        OP_MFLO: rd_data = lo_out;
        default: rd_data = '0;
      endcase
`ifdef HILO_BYPASS_EN
      if (state == ST_WAIT && mult_finished) begin
        case (op_code)
          OP_MFHI: rd_data = mult_hi;
          OP_MFLO: rd_data = mult_lo;
          default: rd_data = '0;
        endcase
      end
`endif
    end
  end

endmodule
